// File: rtl/pulse_sequencer.sv
// Spin-echo / CPMG pulse-train sequencer: one train per repetition period, driving the
// Pulse, Sync and Block lines from a config snapshot taken at each period start.
module pulse_sequencer #(
  parameter int unsigned CW = 32,
  parameter int unsigned NW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          trigger,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] sync_len,
  input  logic [CW-1:0] pre_len,
  input  logic [CW-1:0] p1_len,
  input  logic [CW-1:0] delay,
  input  logic [CW-1:0] p2_len,
  input  logic [NW-1:0] n_p2,
  input  logic [CW-1:0] post_len,
  output logic          pulse,
  output logic          sync,
  output logic          block,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [2:0] {
    StIdle, StPre, StP1, StGap, StP2, StGap2, StPost, StDone
  } state_e;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] sync_len;
    logic [CW-1:0] pre_len;
    logic [CW-1:0] p1_len;
    logic [CW-1:0] delay;
    logic [CW-1:0] p2_len;
    logic [CW-1:0] post_len;
    logic [NW-1:0] n_p2;
  } cfg_t;

  typedef struct packed {
    state_e        st;
    logic [NW-1:0] echo;
  } res_t;

  // Walk forward from a target state past every zero-length state. echo counts P2s not
  // yet started; landing on P2 consumes one.
  function automatic res_t resolve(input state_e st_in, input logic [NW-1:0] echo_in,
                                   input cfg_t c);
    res_t r;
    r.st   = st_in;
    r.echo = echo_in;
    if (r.st == StPre && c.pre_len == '0) r.st = StP1;
    if (r.st == StP1 && c.p1_len == '0) r.st = StGap;
    if (r.st == StGap) begin
      if (r.echo == '0)        r.st = StPost;
      else if (c.delay == '0)  r.st = StP2;
    end
    if (r.st == StGap2 && c.delay == '0) r.st = StP2;
    if (r.st == StP2) begin
      if (c.p2_len != '0) begin
        r.echo = r.echo - 1'b1;
      end else if (c.delay != '0) begin
        r.echo = r.echo - 1'b1;
        r.st   = (r.echo == '0) ? StPost : StGap2;
      end else begin
        // Zero-width echoes with zero spacing collapse to nothing.
        r.echo = '0;
        r.st   = StPost;
      end
    end
    if (r.st == StPost && c.post_len == '0) r.st = StDone;
    return r;
  endfunction

  function automatic logic [CW:0] dur(input state_e st, input cfg_t c);
    unique case (st)
      StPre:   dur = {1'b0, c.pre_len};
      StP1:    dur = {1'b0, c.p1_len};
      StGap:   dur = {1'b0, c.delay};
      StP2:    dur = {1'b0, c.p2_len};
      StGap2:  dur = {c.delay, 1'b0};
      StPost:  dur = {1'b0, c.post_len};
      default: dur = '0;
    endcase
  endfunction

  cfg_t          cfg_q, cfg_d, cfg_in;
  state_e        state_q, state_d, target;
  logic [NW-1:0] echo_q, echo_d;
  logic [CW-1:0] cnt_q, cnt_d, per_eff;
  logic [CW:0]   tcnt_q, tcnt_d;
  logic          overrun_q, overrun_d;
  logic          pulse_q, pulse_d, sync_q, sync_d, block_q, block_d, busy_q, busy_d;
  logic          last, start;
  res_t          r_adv, r_start;

  always_comb begin
    cfg_in = '{period: period, sync_len: sync_len, pre_len: pre_len, p1_len: p1_len,
               delay: delay, p2_len: p2_len, post_len: post_len, n_p2: n_p2};
    per_eff = (cfg_q.period < CW'(2)) ? CW'(2) : cfg_q.period;
    last    = (cnt_q == per_eff - 1'b1);

    unique case (state_q)
      StPre:   target = StP1;
      StP1:    target = StGap;
      StGap:   target = StP2;
      StP2:    target = (echo_q == '0) ? StPost : StGap2;
      StGap2:  target = StP2;
      StPost:  target = StDone;
      default: target = StDone;
    endcase
    r_adv   = resolve(target, echo_q, cfg_q);
    r_start = resolve(StPre, n_p2, cfg_in);

    cfg_d     = cfg_q;
    state_d   = state_q;
    echo_d    = echo_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    overrun_d = overrun_q;
    start     = 1'b0;

    if (state_q == StIdle) begin
      if (enable || trigger) begin
        start     = 1'b1;
        overrun_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (state_q != StDone) begin
        if (tcnt_q + 1'b1 == dur(state_q, cfg_q)) begin
          tcnt_d  = '0;
          state_d = r_adv.st;
          echo_d  = r_adv.echo;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      if (last) begin
        if (state_q != StDone) overrun_d = 1'b1;
        if (enable) begin
          start = 1'b1;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
          tcnt_d  = '0;
          echo_d  = '0;
        end
      end
    end

    if (start) begin
      cfg_d   = cfg_in;
      cnt_d   = '0;
      tcnt_d  = '0;
      state_d = r_start.st;
      echo_d  = r_start.echo;
    end

    // Outputs are decoded from next state so they line up with the registered state.
    pulse_d = (state_d == StP1) || (state_d == StP2);
    block_d = (state_d != StIdle) && (state_d != StDone);
    busy_d  = (state_d != StIdle);
    sync_d  = busy_d && (cnt_d < cfg_d.sync_len);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q     <= '0;
      state_q   <= StIdle;
      echo_q    <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      overrun_q <= 1'b0;
      pulse_q   <= 1'b0;
      sync_q    <= 1'b0;
      block_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      state_q   <= state_d;
      echo_q    <= echo_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      overrun_q <= overrun_d;
      pulse_q   <= pulse_d;
      sync_q    <= sync_d;
      block_q   <= block_d;
      busy_q    <= busy_d;
    end
  end

  assign pulse   = pulse_q;
  assign sync    = sync_q;
  assign block   = block_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: a timeline model pushes per-cycle expected outputs
// for each period; a monitor pops one entry for every busy cycle and compares.
module tb_pulse_sequencer;
  localparam int unsigned CW = 32;
  localparam int unsigned NW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, trigger;
  logic [CW-1:0] period, sync_len, pre_len, p1_len, delay, p2_len, post_len;
  logic [NW-1:0] n_p2;
  logic          pulse, sync, block, busy, overrun;

  pulse_sequencer #(.CW(CW), .NW(NW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .period(period), .sync_len(sync_len), .pre_len(pre_len), .p1_len(p1_len),
    .delay(delay), .p2_len(p2_len), .n_p2(n_p2), .post_len(post_len),
    .pulse(pulse), .sync(sync), .block(block), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned period, sync_len, pre, p1, delay, p2, n, post;
  } tcfg_t;

  logic [3:0] exp_q[$];  // {overrun, pulse, sync, block}
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input tcfg_t c);
    period   = c.period;
    sync_len = c.sync_len;
    pre_len  = c.pre;
    p1_len   = c.p1;
    delay    = c.delay;
    p2_len   = c.p2;
    n_p2     = NW'(c.n);
    post_len = c.post;
  endtask

  function automatic tcfg_t rand_cfg();
    tcfg_t c;
    c.period   = $urandom_range(0, 120);
    c.sync_len = $urandom_range(0, 130);
    c.pre      = $urandom_range(0, 10);
    c.p1       = $urandom_range(0, 10);
    c.delay    = $urandom_range(0, 15);
    c.p2       = $urandom_range(0, 10);
    c.n        = $urandom_range(0, 4);
    c.post     = $urandom_range(0, 10);
    return c;
  endfunction

  // Timeline model: lay pulses out as absolute intervals, then sample per cycle.
  task automatic push_period(input tcfg_t c, input bit ov, output bit ovr);
    int unsigned ps[$];
    int unsigned pe[$];
    int unsigned per, t, bend;
    bit pul;
    per = (c.period < 2) ? 2 : c.period;
    t = c.pre;
    ps.push_back(t);
    pe.push_back(t + c.p1);
    t += c.p1;
    if (c.n > 0) begin
      t += c.delay;
      for (int k = 0; k < int'(c.n); k++) begin
        ps.push_back(t);
        pe.push_back(t + c.p2);
        t += c.p2;
        if (k < int'(c.n) - 1) t += 2 * c.delay;
      end
    end
    bend = t + c.post;
    ovr  = (bend >= per);
    for (int unsigned cyc = 0; cyc < per; cyc++) begin
      pul = 1'b0;
      foreach (ps[i]) if (cyc >= ps[i] && cyc < pe[i]) pul = 1'b1;
      exp_q.push_back({ov, pul, cyc < c.sync_len, cyc < bend});
    end
  endtask

  task automatic run(input tcfg_t c, input bit oneshot, input int k_in);
    int unsigned per;
    int k, drop, waited;
    bit ovr, ov;
    per = (c.period < 2) ? 2 : c.period;
    k   = oneshot ? 1 : k_in;
    ov  = 1'b0;
    @(negedge clk);
    apply(c);
    for (int i = 0; i < k; i++) begin
      push_period(c, ov, ovr);
      if (ovr) ov = 1'b1;
    end
    if (oneshot) trigger = 1'b1;
    else enable = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    drop = (k - 1) * int'(per) + int'($urandom_range(0, per - 1));
    repeat (drop) @(negedge clk);
    enable = 1'b0;
    apply(rand_cfg());  // latched copy must be unaffected
    if (oneshot) begin
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    check("overrun_idle", overrun, ov);
    check("busy_idle", busy, 1'b0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (busy) begin
        if (exp_q.size() == 0) check("unexpected_busy", 1, 0);
        else check("out_word", {overrun, pulse, sync, block}, exp_q.pop_front());
      end else begin
        check("idle_outputs", {pulse, sync, block}, 3'b000);
      end
    end
  end

  initial begin
    tcfg_t t1, t2, t3, t6;
    t1 = '{period: 100, sync_len: 2, pre: 3, p1: 4, delay: 10, p2: 8, n: 1, post: 5};
    t2 = t1; t2.n = 3;
    t3 = t1; t3.period = 20;
    t6 = t1; t6.n = 0; t6.p1 = 0;

    reset = 1'b1; enable = 1'b0; trigger = 1'b0;
    apply(t1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {pulse, sync, block, busy, overrun}, 5'b0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    run(t1, 1'b0, 2);
    run(t2, 1'b0, 1);
    run(t3, 1'b0, 2);
    run(t1, 1'b1, 1);
    run(t6, 1'b0, 1);
    for (int i = 0; i < 25; i++) run(rand_cfg(), 1'($urandom_range(0, 1)),
                                    int'($urandom_range(1, 3)));

    // Reset inside the P2 of a single-echo train.
    mon_en = 1'b0;
    @(negedge clk);
    apply(t1);
    enable = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    check("pulse_before_reset", pulse, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset", {pulse, sync, block, busy, overrun}, 5'b0);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {pulse, sync, block, busy}, 4'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
